dac_pio_sequencer: RTL

Timed sample sequencer for the 20-bit DAC output port. It accepts samples from the HPS over an Avalon-MM CSR slave into an internal FIFO. It pops one sample per programmed sample period and writes it to the DAC PIO (address 0) through an Avalon-MM master with waitrequest. It sits between the HPS lightweight bridge and the DAC PIO slave, replacing direct software writes so the update rate is jitter-free.

---
 rtl/dac_seq_pkg.sv | 27 ++
 rtl/dac_seq_fifo.sv | 57 +++++
 rtl/dac_pio_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// Shared CSR map, CTRL/STATUS bit positions and sequencer FSM states for dac_pio_sequencer.
package dac_seq_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_DIV    = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_THRESH = 3'd4;

   localparam int CTRL_RUN    = 0;
   localparam int CTRL_HOLD   = 1;
   localparam int CTRL_FLUSH  = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_UNDERRUN  = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_LEVEL_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/dac_seq_fifo.sv
// Sample FIFO: push/pop/flush, level visible 1 cycle after push; head is combinational.
// A pop at full frees room for a same-cycle push; flush beats a same-cycle push.
module dac_seq_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 20,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [W-1:0]     head_dat,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (level == LVL_W'(DEPTH));
   assign empty    = (level == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            level <= level + LVL_W'(1);
         else if (do_pop && !do_push)
            level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/dac_pio_sequencer.sv
// Timed DAC sequencer: CSR-fed FIFO drained one sample per DIV+1 clk to the DAC PIO, write strobe 1 cycle after tick,
// held through m_waitrequest. DAC_SEQ_IRQ_EN adds THRESH, CTRL.IRQ_EN and the level irq.
module dac_pio_sequencer
   import dac_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DATA_W     = 20,
   parameter int DIV_W      = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  csr_address,
   input  logic        csr_chipselect,
   input  logic        csr_write_n,
   input  logic [31:0] csr_writedata,
   output logic [31:0] csr_readdata,
   output logic [1:0]  m_address,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        irq
);

   logic              csr_wr;
   logic              wr_data, wr_ctrl, wr_div, wr_status;
   logic              run, hold, flush;
   logic [DIV_W-1:0]  div_reg, div_cnt;
   logic              tick;
   logic              underrun, ovf, underrun_set, ovf_set;
   logic              fifo_full, fifo_empty, pop_fire;
   logic [LVL_W-1:0]  fifo_level;
   logic [DATA_W-1:0] fifo_head, sample_q, load_dat;
   logic              load_en;
   seq_state_t        state, state_nxt;
   logic              unused_wdata;

   assign unused_wdata = ^csr_writedata;

   assign csr_wr    = csr_chipselect && !csr_write_n;
   assign wr_data   = csr_wr && (csr_address == ADDR_DATA);
   assign wr_ctrl   = csr_wr && (csr_address == ADDR_CTRL);
   assign wr_div    = csr_wr && (csr_address == ADDR_DIV);
   assign wr_status = csr_wr && (csr_address == ADDR_STATUS);
   assign flush     = wr_ctrl && csr_writedata[CTRL_FLUSH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run     <= 1'b0;
         hold    <= 1'b0;
         div_reg <= '0;
      end else begin
         if (wr_ctrl) begin
            run  <= csr_writedata[CTRL_RUN];
            hold <= csr_writedata[CTRL_HOLD];
         end
         if (wr_div) div_reg <= csr_writedata[DIV_W-1:0];
      end
   end

   // The counter only samples div_reg on reload, so DIV writes never shorten a period in flight.
   assign tick = run && (div_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         div_cnt <= '0;
      else if (!run || div_cnt == '0)
         div_cnt <= div_reg;
      else
         div_cnt <= div_cnt - DIV_W'(1);
   end

   dac_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_W),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (wr_data),
      .push_dat (csr_writedata[DATA_W-1:0]),
      .pop      (pop_fire),
      .flush    (flush),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      pop_fire     = 1'b0;
      load_en      = 1'b0;
      load_dat     = '0;
      underrun_set = 1'b0;
      case (state)
         IDLE: begin
            if (run) state_nxt = WAIT;
         end
         WAIT: begin
            if (!run) begin
               state_nxt = IDLE;
            end else if (tick) begin
               if (!fifo_empty) begin
                  pop_fire  = 1'b1;
                  load_en   = 1'b1;
                  load_dat  = fifo_head;
                  state_nxt = WRITE;
               end else begin
                  underrun_set = 1'b1;
                  if (!hold) begin
                     load_en   = 1'b1;
                     state_nxt = WRITE;
                  end
               end
            end
         end
         WRITE: begin
            // A period that expires while the slave stalls is lost, not queued.
            if (tick) underrun_set = 1'b1;
            if (!m_waitrequest) state_nxt = run ? WAIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     sample_q <= '0;
      else if (load_en) sample_q <= load_dat;
   end

   assign m_address   = 2'b00;
   assign m_write_n   = (state != WRITE);
   assign m_writedata = 32'(sample_q);

   assign ovf_set = wr_data && fifo_full && !pop_fire && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (underrun_set)
            underrun <= 1'b1;
         else if (wr_status && csr_writedata[ST_UNDERRUN])
            underrun <= 1'b0;
         if (ovf_set)
            ovf <= 1'b1;
         else if (wr_status && csr_writedata[ST_OVF])
            ovf <= 1'b0;
      end
   end

`ifdef DAC_SEQ_IRQ_EN
   logic             irq_en;
   logic [LVL_W-1:0] thresh;
   logic             irq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         thresh <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= csr_writedata[CTRL_IRQ_EN];
         if (csr_wr && csr_address == ADDR_THRESH) thresh <= csr_writedata[LVL_W-1:0];
         irq_q <= irq_en && run && (fifo_level <= thresh);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      csr_readdata = '0;
      case (csr_address)
         ADDR_CTRL: begin
            csr_readdata[CTRL_RUN]  = run;
            csr_readdata[CTRL_HOLD] = hold;
`ifdef DAC_SEQ_IRQ_EN
            csr_readdata[CTRL_IRQ_EN] = irq_en;
`endif
         end
         ADDR_DIV: csr_readdata = 32'(div_reg);
         ADDR_STATUS: begin
            csr_readdata[ST_EMPTY]    = fifo_empty;
            csr_readdata[ST_FULL]     = fifo_full;
            csr_readdata[ST_UNDERRUN] = underrun;
            csr_readdata[ST_OVF]      = ovf;
            csr_readdata[ST_LEVEL_LSB +: LVL_W] = fifo_level;
         end
`ifdef DAC_SEQ_IRQ_EN
         ADDR_THRESH: csr_readdata = 32'(thresh);
`endif
         default: csr_readdata = '0;
      endcase
   end

endmodule
